// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard scoreboard bundle.
// master: pipeline side, drives ID/EX/MEM status and the memory stalls, and receives
//         the per-stage write enables, bubble and flush controls.
// slave:  hazard scoreboard side.
interface hazard_scoreboard_if #(
    parameter int unsigned REG_W = 5
);
    logic [REG_W-1:0] ID_rs1_i;
    logic [REG_W-1:0] ID_rs2_i;
    logic             ID_rs1_used_i;
    logic             ID_rs2_used_i;
    logic             EX_valid_i;
    logic             EX_mem_read_i;
    logic [REG_W-1:0] EX_rd_i;
    logic             EX_muldiv_i;
    logic             EX_br_taken_i;
    logic             MEM_valid_i;
    logic             MEM_mem_read_i;
    logic [REG_W-1:0] MEM_rd_i;
    logic             imem_stall_i;
    logic             dmem_stall_i;

    logic             HD_PC_write_o;
    logic             HD_IF_ID_write_o;
    logic             HD_ID_EX_write_o;
    logic             HD_EX_MEM_write_o;
    logic             HD_MEM_WB_write_o;
    logic             HD_controlmux_sel_o;
    logic             HD_ex_mem_bubble_o;
    logic             HD_IF_ID_flush_o;
    logic             HD_md_busy_o;

    modport master (
        output ID_rs1_i, ID_rs2_i, ID_rs1_used_i, ID_rs2_used_i,
               EX_valid_i, EX_mem_read_i, EX_rd_i, EX_muldiv_i, EX_br_taken_i,
               MEM_valid_i, MEM_mem_read_i, MEM_rd_i, imem_stall_i, dmem_stall_i,
        input  HD_PC_write_o, HD_IF_ID_write_o, HD_ID_EX_write_o, HD_EX_MEM_write_o,
               HD_MEM_WB_write_o, HD_controlmux_sel_o, HD_ex_mem_bubble_o,
               HD_IF_ID_flush_o, HD_md_busy_o
    );

    modport slave (
        input  ID_rs1_i, ID_rs2_i, ID_rs1_used_i, ID_rs2_used_i,
               EX_valid_i, EX_mem_read_i, EX_rd_i, EX_muldiv_i, EX_br_taken_i,
               MEM_valid_i, MEM_mem_read_i, MEM_rd_i, imem_stall_i, dmem_stall_i,
        output HD_PC_write_o, HD_IF_ID_write_o, HD_ID_EX_write_o, HD_EX_MEM_write_o,
               HD_MEM_WB_write_o, HD_controlmux_sel_o, HD_ex_mem_bubble_o,
               HD_IF_ID_flush_o, HD_md_busy_o
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage rv32i pipeline: load-use detection, mul/div
// occupancy, memory-stall freeze and taken-branch flush, plus saturating per-cause
// stall counters.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   hz              pipeline status in / stage write enables, bubble, flush out
//                   (combinational, same-cycle)
//   perf_clear_i    synchronous clear of all counters
//   cnt_*_o         load-use, memory stall, mul/div stall and flush counters
module hazard_scoreboard #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned LU_DEPTH = 1,
    parameter int unsigned MD_LAT   = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_scoreboard_if.slave hz,
    input  logic             perf_clear_i,
    output logic [CNT_W-1:0] cnt_load_use_o,
    output logic [CNT_W-1:0] cnt_mem_stall_o,
    output logic [CNT_W-1:0] cnt_md_stall_o,
    output logic [CNT_W-1:0] cnt_flush_o
);
    localparam int unsigned MD_W = $clog2(MD_LAT) + 1;
    localparam logic [MD_W-1:0]  MD_IDLE  = '0;
    localparam logic [MD_W-1:0]  MD_LAST  = MD_W'(1);
    localparam logic [MD_W-1:0]  MD_START = MD_W'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic             md_stall;
    logic             mem_stall;
    logic             lu_ex, lu_mem, lu;
    logic             sel_mem, sel_md, sel_br, sel_lu;
    logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d;
    logic [CNT_W-1:0] cnt_mem_q, cnt_mem_d;
    logic [CNT_W-1:0] cnt_md_q, cnt_md_d;
    logic [CNT_W-1:0] cnt_fl_q, cnt_fl_d;

    // A source in ID depends on a nonzero destination.
    function automatic logic hit(input logic [REG_W-1:0] rd,
                                 input logic [REG_W-1:0] rs1, input logic rs1_used,
                                 input logic [REG_W-1:0] rs2, input logic rs2_used);
        return (rd != '0) && (((rd == rs1) && rs1_used) || ((rd == rs2) && rs2_used));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
    endfunction

    assign mem_stall = hz.imem_stall_i | hz.dmem_stall_i;
    assign lu_ex  = hz.EX_valid_i & hz.EX_mem_read_i &
                    hit(hz.EX_rd_i, hz.ID_rs1_i, hz.ID_rs1_used_i, hz.ID_rs2_i, hz.ID_rs2_used_i);
    // The MEM-stage load shadow only participates in the deeper configuration.
    assign lu_mem = (LU_DEPTH == 2) && hz.MEM_valid_i && hz.MEM_mem_read_i &&
                    hit(hz.MEM_rd_i, hz.ID_rs1_i, hz.ID_rs1_used_i, hz.ID_rs2_i, hz.ID_rs2_used_i);
    assign lu = lu_ex | lu_mem;

    // Mul/div occupancy: count down the remaining EX cycles; the last cycle releases EX
    // without re-triggering on the same op. Memory stalls freeze the count.
    always_comb begin
        md_cnt_d = md_cnt_q;
        md_stall = 1'b0;
        if (md_cnt_q == MD_IDLE) begin
            if (hz.EX_valid_i && hz.EX_muldiv_i && (MD_LAT > 1)) begin
                md_stall = 1'b1;
                md_cnt_d = MD_START;
            end
        end else begin
            md_stall = (md_cnt_q > MD_LAST);
            md_cnt_d = md_cnt_q - MD_LAST;
        end
        if (mem_stall) begin
            md_cnt_d = md_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_cnt_q <= MD_IDLE;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    // Prioritised stage control; everything is held quiet while reset is asserted.
    always_comb begin
        hz.HD_PC_write_o       = 1'b1;
        hz.HD_IF_ID_write_o    = 1'b1;
        hz.HD_ID_EX_write_o    = 1'b1;
        hz.HD_EX_MEM_write_o   = 1'b1;
        hz.HD_MEM_WB_write_o   = 1'b1;
        hz.HD_controlmux_sel_o = 1'b1;
        hz.HD_ex_mem_bubble_o  = 1'b0;
        hz.HD_IF_ID_flush_o    = 1'b0;
        hz.HD_md_busy_o        = rst & md_stall;
        sel_mem = 1'b0;
        sel_md  = 1'b0;
        sel_br  = 1'b0;
        sel_lu  = 1'b0;
        if (!rst) begin
            hz.HD_PC_write_o     = 1'b0;
            hz.HD_IF_ID_write_o  = 1'b0;
            hz.HD_ID_EX_write_o  = 1'b0;
            hz.HD_EX_MEM_write_o = 1'b0;
            hz.HD_MEM_WB_write_o = 1'b0;
        end else if (mem_stall) begin
            sel_mem = 1'b1;
            hz.HD_PC_write_o     = 1'b0;
            hz.HD_IF_ID_write_o  = 1'b0;
            hz.HD_ID_EX_write_o  = 1'b0;
            hz.HD_EX_MEM_write_o = 1'b0;
            hz.HD_MEM_WB_write_o = 1'b0;
        end else if (md_stall) begin
            sel_md = 1'b1;
            hz.HD_PC_write_o      = 1'b0;
            hz.HD_IF_ID_write_o   = 1'b0;
            hz.HD_ID_EX_write_o   = 1'b0;
            hz.HD_ex_mem_bubble_o = 1'b1;
        end else if (hz.EX_br_taken_i) begin
            // Wrong-path ID instruction: flush it rather than stall on it.
            sel_br = 1'b1;
            hz.HD_IF_ID_flush_o    = 1'b1;
            hz.HD_controlmux_sel_o = 1'b0;
        end else if (lu) begin
            sel_lu = 1'b1;
            hz.HD_PC_write_o       = 1'b0;
            hz.HD_IF_ID_write_o    = 1'b0;
            hz.HD_controlmux_sel_o = 1'b0;
        end
    end

    // Counter next state: clear wins over increment.
    always_comb begin
        cnt_lu_d  = sat_inc(cnt_lu_q, sel_lu);
        cnt_mem_d = sat_inc(cnt_mem_q, sel_mem);
        cnt_md_d  = sat_inc(cnt_md_q, sel_md);
        cnt_fl_d  = sat_inc(cnt_fl_q, sel_br);
        if (perf_clear_i) begin
            cnt_lu_d  = '0;
            cnt_mem_d = '0;
            cnt_md_d  = '0;
            cnt_fl_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_lu_q  <= '0;
            cnt_mem_q <= '0;
            cnt_md_q  <= '0;
            cnt_fl_q  <= '0;
        end else begin
            cnt_lu_q  <= cnt_lu_d;
            cnt_mem_q <= cnt_mem_d;
            cnt_md_q  <= cnt_md_d;
            cnt_fl_q  <= cnt_fl_d;
        end
    end

    assign cnt_load_use_o  = cnt_lu_q;
    assign cnt_mem_stall_o = cnt_mem_q;
    assign cnt_md_stall_o  = cnt_md_q;
    assign cnt_flush_o     = cnt_fl_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: two instances with different
// configurations (LU_DEPTH/MD_LAT/CNT_W = 1/4/32 and 2/2/4) share one stimulus.
module tb_hazard_scoreboard;
    typedef struct packed {
        logic [4:0] rs1, rs2, exrd, memrd;
        logic rs1u, rs2u, exv, exld, exmd, br, memv, memld, ist, dst, clr;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [8:0] e0;
        logic [8:0] e1;
    } vec_t;

    localparam int unsigned LU_CFG  [2] = '{1, 2};
    localparam int unsigned LAT_CFG [2] = '{4, 2};
    localparam int unsigned CW_CFG  [2] = '{32, 4};
    // Output vector: {PC, IF_ID, ID_EX, EX_MEM, MEM_WB write, controlmux_sel, bubble, flush, md_busy}
    localparam logic [8:0] O_RUN   = 9'h1F8;
    localparam logic [8:0] O_LU    = 9'h070;
    localparam logic [8:0] O_FLUSH = 9'h1F2;
    localparam logic [8:0] O_FRZ   = 9'h008;
    localparam int NV = 11;

    logic clk = 1'b0;
    logic rst;
    in_t  cur;
    logic [8:0]  dut_out [2];
    logic [31:0] cnt_act [2][4];
    logic [31:0] c0 [4];
    logic [3:0]  c1 [4];

    int    n_checks = 0;
    int    n_fail = 0;
    int    occ [2];
    longint m_cnt [2][4];
    vec_t  tv [NV];

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_W(5)) hif [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_drv
        assign hif[g].ID_rs1_i       = cur.rs1;
        assign hif[g].ID_rs2_i       = cur.rs2;
        assign hif[g].ID_rs1_used_i  = cur.rs1u;
        assign hif[g].ID_rs2_used_i  = cur.rs2u;
        assign hif[g].EX_valid_i     = cur.exv;
        assign hif[g].EX_mem_read_i  = cur.exld;
        assign hif[g].EX_rd_i        = cur.exrd;
        assign hif[g].EX_muldiv_i    = cur.exmd;
        assign hif[g].EX_br_taken_i  = cur.br;
        assign hif[g].MEM_valid_i    = cur.memv;
        assign hif[g].MEM_mem_read_i = cur.memld;
        assign hif[g].MEM_rd_i       = cur.memrd;
        assign hif[g].imem_stall_i   = cur.ist;
        assign hif[g].dmem_stall_i   = cur.dst;
        assign dut_out[g] = {hif[g].HD_PC_write_o, hif[g].HD_IF_ID_write_o,
                             hif[g].HD_ID_EX_write_o, hif[g].HD_EX_MEM_write_o,
                             hif[g].HD_MEM_WB_write_o, hif[g].HD_controlmux_sel_o,
                             hif[g].HD_ex_mem_bubble_o, hif[g].HD_IF_ID_flush_o,
                             hif[g].HD_md_busy_o};
    end

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        assign cnt_act[0][k] = c0[k];
        assign cnt_act[1][k] = 32'(c1[k]);
    end

    hazard_scoreboard #(.REG_W(5), .LU_DEPTH(1), .MD_LAT(4), .CNT_W(32)) u_dut0 (
        .clk(clk), .rst(rst), .hz(hif[0]), .perf_clear_i(cur.clr),
        .cnt_load_use_o(c0[0]), .cnt_mem_stall_o(c0[1]),
        .cnt_md_stall_o(c0[2]), .cnt_flush_o(c0[3])
    );

    hazard_scoreboard #(.REG_W(5), .LU_DEPTH(2), .MD_LAT(2), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .hz(hif[1]), .perf_clear_i(cur.clr),
        .cnt_load_use_o(c1[0]), .cnt_mem_stall_o(c1[1]),
        .cnt_md_stall_o(c1[2]), .cnt_flush_o(c1[3])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic in_t mk(input logic [4:0] rs1, input logic rs1u,
                               input logic [4:0] rs2, input logic rs2u,
                               input logic exv, input logic exld, input logic [4:0] exrd,
                               input logic memv, input logic memld, input logic [4:0] memrd,
                               input logic br, input logic ist, input logic dst);
        in_t v;
        v = '0;
        v.rs1 = rs1; v.rs1u = rs1u; v.rs2 = rs2; v.rs2u = rs2u;
        v.exv = exv; v.exld = exld; v.exrd = exrd;
        v.memv = memv; v.memld = memld; v.memrd = memrd;
        v.br = br; v.ist = ist; v.dst = dst;
        return v;
    endfunction

    function automatic bit depends(input logic [4:0] rd, input in_t v);
        return (rd != 5'd0) && ((v.rs1u && v.rs1 == rd) || (v.rs2u && v.rs2 == rd));
    endfunction

    // Reference: occ = EX cycles still owed to the mul/div op currently in EX.
    // cause: 0 load-use, 1 memory stall, 2 mul/div stall, 3 flush, -1 none.
    function automatic logic [8:0] model_eval(input int d, input in_t v, input int occ_in,
                                              output int occ_nx, output int cause);
        bit mem, md, lu;
        int eff;
        mem = v.ist || v.dst;
        eff = occ_in;
        if (eff == 0 && v.exv && v.exmd && LAT_CFG[d] > 1) eff = int'(LAT_CFG[d]);
        md = (eff > 1);
        occ_nx = mem ? occ_in : ((eff > 0) ? eff - 1 : 0);
        lu = (v.exv && v.exld && depends(v.exrd, v)) ||
             (LU_CFG[d] == 2 && v.memv && v.memld && depends(v.memrd, v));
        if (mem)       begin cause = 1;  return {8'b0000_0100, md}; end
        else if (md)   begin cause = 2;  return 9'b00011_1_1_0_1; end
        else if (v.br) begin cause = 3;  return O_FLUSH; end
        else if (lu)   begin cause = 0;  return O_LU; end
        cause = -1;
        return O_RUN;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            occ[d] = 0;
            for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
        end
    endtask

    // One clock cycle: apply, check outputs mid-cycle, check counters after the edge.
    task automatic cycle(input in_t v, output logic [8:0] o0, output logic [8:0] o1);
        logic [8:0] e;
        int nx, cause;
        longint maxv;
        cur = v;
        @(negedge clk);
        o0 = dut_out[0];
        o1 = dut_out[1];
        for (int d = 0; d < 2; d++) begin
            e = model_eval(d, v, occ[d], nx, cause);
            check($sformatf("ctl_dut%0d", d), 64'(dut_out[d]), 64'(e));
            occ[d] = nx;
            maxv = (64'sd1 <<< CW_CFG[d]) - 1;
            if (v.clr) begin
                for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
            end else if (cause >= 0 && m_cnt[d][cause] < maxv) begin
                m_cnt[d][cause]++;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++)
                check($sformatf("cnt%0d_dut%0d", k, d), 64'(cnt_act[d][k]), 64'(m_cnt[d][k]));
    endtask

    initial begin
        logic [8:0] o0, o1;
        logic [31:0] base_md, base_mem;
        in_t idle, mul, v;

        idle = '0;
        mul = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        mul.exmd = 1'b1;

        tv[0]  = '{"idle",       mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0), O_RUN,   O_RUN};
        tv[1]  = '{"ex_lu_rs1",  mk(5,1, 2,1, 1,1,5, 0,0,0, 0,0,0), O_LU,    O_LU};
        tv[2]  = '{"ex_lu_rd0",  mk(0,1, 0,1, 1,1,0, 0,0,0, 0,0,0), O_RUN,   O_RUN};
        tv[3]  = '{"rs1_unused", mk(5,0, 2,1, 1,1,5, 0,0,0, 0,0,0), O_RUN,   O_RUN};
        tv[4]  = '{"ex_invalid", mk(1,1, 9,1, 0,1,9, 0,0,0, 0,0,0), O_RUN,   O_RUN};
        tv[5]  = '{"mem_lu_rs2", mk(1,1, 7,1, 1,0,7, 1,1,7, 0,0,0), O_RUN,   O_LU};
        tv[6]  = '{"mem_inval",  mk(1,1, 7,1, 0,0,0, 0,1,7, 0,0,0), O_RUN,   O_RUN};
        tv[7]  = '{"br_over_lu", mk(5,1, 2,1, 1,1,5, 0,0,0, 1,0,0), O_FLUSH, O_FLUSH};
        tv[8]  = '{"dmem_stall", mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,1), O_FRZ,   O_FRZ};
        tv[9]  = '{"imem_lu",    mk(5,1, 2,1, 1,1,5, 0,0,0, 0,1,0), O_FRZ,   O_FRZ};
        tv[10] = '{"imem_br",    mk(0,0, 0,0, 1,0,4, 0,0,0, 1,1,0), O_FRZ,   O_FRZ};

        // Reset holds everything quiet regardless of inputs.
        rst = 1'b0;
        cur = mul;
        cur.br = 1'b1;
        model_reset();
        #12;
        check("rst_ctl_dut0", 64'(dut_out[0]), 64'(O_FRZ));
        check("rst_ctl_dut1", 64'(dut_out[1]), 64'(O_FRZ));
        check("rst_cnt_dut0", 64'(cnt_act[0][0]), 64'd0);
        cur = idle;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            cycle(tv[i].in, o0, o1);
            check({tv[i].name, "_lu1"}, 64'(o0), 64'(tv[i].e0));
            check({tv[i].name, "_lu2"}, 64'(o1), 64'(tv[i].e1));
        end

        // Held mul, then a back-to-back second mul: busy pattern 1,1,1,0 twice.
        base_md = cnt_act[0][2];
        for (int i = 0; i < 8; i++) begin
            cycle(mul, o0, o1);
            check($sformatf("md_busy_c%0d", i), 64'(o0[0]), (i % 4 == 3) ? 64'd0 : 64'd1);
            check($sformatf("md_bubble_c%0d", i), 64'(o0[2]), (i % 4 == 3) ? 64'd0 : 64'd1);
        end
        check("md_cnt_delta", 64'(cnt_act[0][2] - base_md), 64'd6);
        cycle(idle, o0, o1);

        // Data stall for two cycles inside the busy window freezes the occupancy.
        base_md = cnt_act[0][2];
        base_mem = cnt_act[0][1];
        for (int i = 0; i < 6; i++) begin
            v = mul;
            v.dst = (i == 1 || i == 2);
            cycle(v, o0, o1);
            check($sformatf("frz_busy_c%0d", i), 64'(o0[0]), (i == 5) ? 64'd0 : 64'd1);
            if (i == 1 || i == 2) check($sformatf("frz_wr_c%0d", i), 64'(o0[8:4]), 64'd0);
        end
        check("frz_md_delta", 64'(cnt_act[0][2] - base_md), 64'd3);
        check("frz_mem_delta", 64'(cnt_act[0][1] - base_mem), 64'd2);
        cycle(idle, o0, o1);

        // Saturation of the 4-bit counters, then clear beating an increment.
        v = idle;
        v.dst = 1'b1;
        for (int i = 0; i < 20; i++) cycle(v, o0, o1);
        check("sat_mem_dut1", 64'(cnt_act[1][1]), 64'd15);
        v.clr = 1'b1;
        cycle(v, o0, o1);
        check("clr_mem_dut0", 64'(cnt_act[0][1]), 64'd0);
        check("clr_mem_dut1", 64'(cnt_act[1][1]), 64'd0);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            v = '0;
            v.rs1 = 5'($urandom_range(0, 7));
            v.rs2 = 5'($urandom_range(0, 7));
            v.rs1u = 1'($urandom);
            v.rs2u = 1'($urandom);
            v.exv = ($urandom_range(0, 3) != 0);
            v.exld = 1'($urandom);
            v.exrd = 5'($urandom_range(0, 7));
            v.exmd = ($urandom_range(0, 5) == 0);
            v.br = ($urandom_range(0, 6) == 0);
            v.memv = 1'($urandom);
            v.memld = 1'($urandom);
            v.memrd = 5'($urandom_range(0, 7));
            v.ist = ($urandom_range(0, 9) == 0);
            v.dst = ($urandom_range(0, 9) == 0);
            v.clr = ($urandom_range(0, 60) == 0);
            cycle(v, o0, o1);
        end

        // Asynchronous reset in the middle of a mul/div occupancy.
        cycle(idle, o0, o1);
        cycle(mul, o0, o1);
        cur = mul;
        #2;
        check("pre_rst_busy", 64'(dut_out[0][0]), 64'd1);
        rst = 1'b0;
        #1;
        check("rst_busy_dut0", 64'(dut_out[0]), 64'(O_FRZ));
        check("rst_cnt_fl", 64'(cnt_act[0][3]), 64'd0);
        cur = idle;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cycle(mul, o0, o1);
        cycle(idle, o0, o1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
